// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Consumes one bit of a per cycle, then applies a single conditional
// subtraction to bring the accumulator from [0, 2m) into [0, m).
module mont_mult_serial #(
  parameter int WIDTH = 381,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH+1:0] sum_ab;
  logic [WIDTH+1:0] sum_abm;
  logic [WIDTH+1:0] acc_minus_m;
  logic             acc_ge_m;

  // One Montgomery step plus the final-compare terms. The a register
  // shifts right each iteration, so bit 0 is always the current a bit.
  always_comb begin
    sum_ab      = acc_q + (a_q[0] ? {2'b00, b_q} : '0);
    sum_abm     = sum_ab[0] ? (sum_ab + {2'b00, m_q}) : sum_ab;
    acc_ge_m    = (acc_q >= {2'b00, m_q});
    acc_minus_m = acc_q - {2'b00, m_q};
  end

  // Next-state and register-update logic for IDLE -> LOOP -> SUB -> IDLE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = LOOP;
        end
      end
      LOOP: begin
        acc_d = sum_abm >> 1;
        a_d   = a_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = SUB;
        end
      end
      SUB: begin
        result_d = acc_ge_m ? acc_minus_m[WIDTH-1:0] : acc_q[WIDTH-1:0];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
